// File: rtl/key_filter.sv
// ============================================================================
//  Module      : key_filter
//  Description : Push-button debouncer. Synchronises an active-low button pad,
//                requires CNT_MAX+1 cycles of stable level before accepting a
//                change, and emits single-cycle press / release pulses.
//                Optional long-press detection is enabled by defining the
//                macro KEY_LONG_PRESS_EN (adds parameter LONG_MAX and drives
//                key_long); without it key_long is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_filter #(
    parameter int CNT_MAX  = 999_999
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int LONG_MAX = 49_999_999
`endif
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    // Counter must hold the largest terminal count that can be reached.
`ifdef KEY_LONG_PRESS_EN
    localparam int c_CNT_TOP = (LONG_MAX > CNT_MAX) ? LONG_MAX : CNT_MAX;
`else
    localparam int c_CNT_TOP = CNT_MAX;
`endif
    localparam int c_CNT_W = (c_CNT_TOP > 0) ? $clog2(c_CNT_TOP + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_END = c_CNT_W'(CNT_MAX);
`ifdef KEY_LONG_PRESS_EN
    localparam logic [c_CNT_W-1:0] c_LONG_END = c_CNT_W'(LONG_MAX);
`endif

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PRESS_CHK = 2'd1;
    localparam logic [1:0] S_DOWN      = 2'd2;
    localparam logic [1:0] S_REL_CHK   = 2'd3;

    logic               r_sync1;
    logic               r_sync2;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_key_out;
    logic               r_press;
    logic               r_release;
`ifdef KEY_LONG_PRESS_EN
    logic               r_long;
    logic               r_long_done;
`endif

    // Two-flop synchroniser for the asynchronous pad; idles high (released).
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM: any disagreeing sample in a check state restarts the window.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_key_out   <= 1'b1;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_long      <= 1'b0;
            r_long_done <= 1'b0;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_long    <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= S_PRESS_CHK;
                        r_cnt   <= '0;
                    end
                end
                S_PRESS_CHK: begin
                    if (r_sync2) begin
                        // Bounce (including on the terminal cycle): restart.
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != c_CNT_END) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_state     <= S_DOWN;
                        r_key_out   <= 1'b0;
                        r_press     <= 1'b1;
                        r_cnt       <= '0;
`ifdef KEY_LONG_PRESS_EN
                        r_long_done <= 1'b0;
`endif
                    end
                end
                S_DOWN: begin
                    if (r_sync2) begin
                        r_state <= S_REL_CHK;
                        r_cnt   <= '0;
                    end
`ifdef KEY_LONG_PRESS_EN
                    else begin
                        // Saturating hold timer; the done flag stops repeats
                        // until a fresh press is accepted.
                        if (r_cnt != c_LONG_END) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else if (!r_long_done) begin
                            r_long      <= 1'b1;
                            r_long_done <= 1'b1;
                        end
                    end
`endif
                end
                S_REL_CHK: begin
                    if (!r_sync2) begin
                        r_state <= S_DOWN;
                        r_cnt   <= '0;
                    end else if (r_cnt != c_CNT_END) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                        r_key_out <= 1'b1;
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign key_out     = r_key_out;
    assign key_press   = r_press;
    assign key_release = r_release;
`ifdef KEY_LONG_PRESS_EN
    assign key_long    = r_long;
`else
    assign key_long    = 1'b0;
`endif

endmodule

`default_nettype wire
